// File: rtl/return_stack_if.sv
`default_nettype none
// ============================================================================
// return_stack_if : call/return port bundle between controller and stack
// Rev 1.0
// ============================================================================
interface return_stack_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] push_data;
    logic             clr_err;
    logic [WIDTH-1:0] top_data;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, push_data, clr_err,
        input  top_data, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, push_data, clr_err,
        output top_data, count, empty, full, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
// return_stack : LIFO of return addresses with zero-latency top read
// Rev 1.0
// ============================================================================
module return_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  wire            clk,
    input  wire            rst,
    return_stack_if.slave  bus
);
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             wr_en;
    logic [PW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [PW-1:0]    top_idx;
    logic             is_empty;
    logic             is_full;

    // Low bits of count-1 also address the top when count==DEPTH (wraps to DEPTH-1)
    assign top_idx  = count_q[PW-1:0] - PW'(1);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == C_DEPTH);

    always_comb begin
        count_d     = count_q;
        overflow_d  = bus.clr_err ? 1'b0 : overflow_q;
        underflow_d = bus.clr_err ? 1'b0 : underflow_q;
        wr_en       = 1'b0;
        wr_addr     = count_q[PW-1:0];
        wr_data     = bus.push_data;

        unique case ({bus.push, bus.pop})
            2'b11: begin
                wr_en = 1'b1;
                if (is_empty) begin
                    wr_addr     = '0;
                    count_d     = C_ONE;
                    underflow_d = 1'b1;
                end else begin
                    wr_addr = top_idx;
                end
            end
            2'b10: begin
                if (is_full) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + C_ONE;
                end
            end
            2'b01: begin
                if (is_empty) begin
                    underflow_d = 1'b1;
                end else begin
                    count_d = count_q - C_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; writes are suppressed while reset is held
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign bus.top_data  = is_empty ? '0 : mem_q[top_idx];
    assign bus.count     = count_q;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_return_stack.sv
`default_nettype none
// ============================================================================
// tb_return_stack : directed scenarios plus randomized run against a queue model
// Rev 1.0
// ============================================================================
module tb_return_stack;
    localparam int WIDTH = 12;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    return_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue whose back is the top of stack
    logic [WIDTH-1:0] stk [$];
    logic             m_ovf;
    logic             m_unf;

    function automatic logic [WIDTH-1:0] m_top();
        if (stk.size() == 0) return '0;
        return stk[stk.size()-1];
    endfunction

    function automatic logic [CW-1:0] m_count();
        return CW'(stk.size());
    endfunction

    function automatic void model_step(logic p, logic q, logic [WIDTH-1:0] d, logic c);
        logic ev_o;
        logic ev_u;
        ev_o = 1'b0;
        ev_u = 1'b0;
        if (p && q) begin
            if (stk.size() == 0) begin
                stk.push_back(d);
                ev_u = 1'b1;
            end else begin
                stk[stk.size()-1] = d;
            end
        end else if (p) begin
            if (stk.size() < DEPTH) stk.push_back(d);
            else ev_o = 1'b1;
        end else if (q) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else ev_u = 1'b1;
        end
        m_ovf = ev_o ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = ev_u ? 1'b1 : (c ? 1'b0 : m_unf);
    endfunction

    function automatic void model_reset();
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    // Drive one cycle of inputs (called 1 time unit after a rising edge)
    task automatic do_cycle(logic p, logic q, logic [WIDTH-1:0] d, logic c);
        bus.push      = p;
        bus.pop       = q;
        bus.push_data = d;
        bus.clr_err   = c;
        @(posedge clk);
        #1;
        model_step(p, q, d, c);
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        bus.push = 0; bus.pop = 0; bus.push_data = '0; bus.clr_err = 0;
        rst = 1'b0;
        model_reset();
        #3;
        checks++;
        if (bus.count !== 0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.top_data !== '0) begin
            errors++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b ovf=%b unf=%b top=%h expected 0 1 0 0 0 000",
                     bus.count, bus.empty, bus.full, bus.overflow, bus.underflow, bus.top_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        do_cycle(1, 0, 12'h010, 0);
        do_cycle(1, 0, 12'h020, 0);
        do_cycle(1, 0, 12'h030, 0);
        checks++;
        if (bus.count !== 3 || bus.top_data !== 12'h030) begin
            errors++;
            $display("FAIL basic_push3: count=%0d top=%h expected 3 030", bus.count, bus.top_data);
        end
        bus.pop = 1'b1;
        #1;
        checks++;
        if (bus.top_data !== 12'h030) begin
            errors++;
            $display("FAIL basic_same_cycle_top: got %h expected 030", bus.top_data);
        end
        do_cycle(0, 1, '0, 0);
        checks++;
        if (bus.top_data !== 12'h020 || bus.count !== 2) begin
            errors++;
            $display("FAIL basic_after_pop: top=%h count=%0d expected 020 2", bus.top_data, bus.count);
        end
        do_cycle(0, 1, '0, 0);
        do_cycle(0, 1, '0, 0);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= DEPTH; i++) do_cycle(1, 0, WIDTH'(i), 0);
        checks++;
        if (bus.full !== 1'b1 || bus.count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL ovf_full: full=%b count=%0d expected 1 %0d", bus.full, bus.count, DEPTH);
        end
        do_cycle(1, 0, 12'h0FF, 0);
        checks++;
        if (bus.overflow !== 1'b1 || bus.count !== CW'(DEPTH) || bus.top_data !== 12'h008) begin
            errors++;
            $display("FAIL ovf_dropped: ovf=%b count=%0d top=%h expected 1 %0d 008",
                     bus.overflow, bus.count, bus.top_data, DEPTH);
        end
        for (int i = DEPTH; i >= 1; i--) begin
            checks++;
            if (bus.top_data !== WIDTH'(i)) begin
                errors++;
                $display("FAIL ovf_pop_seq: top=%h expected %h", bus.top_data, WIDTH'(i));
            end
            do_cycle(0, 1, '0, 0);
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.top_data !== '0 || bus.count !== 0) begin
            errors++;
            $display("FAIL ovf_drained: empty=%b top=%h count=%0d expected 1 000 0",
                     bus.empty, bus.top_data, bus.count);
        end
        do_cycle(0, 0, '0, 1);
    endtask

    task automatic test_underflow();
        do_cycle(0, 1, '0, 0);
        checks++;
        if (bus.underflow !== 1'b1 || bus.count !== 0) begin
            errors++;
            $display("FAIL unf_set: unf=%b count=%0d expected 1 0", bus.underflow, bus.count);
        end
        do_cycle(0, 0, '0, 1);
        checks++;
        if (bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL unf_clear: unf=%b expected 0", bus.underflow);
        end
        do_cycle(0, 1, '0, 1);
        checks++;
        if (bus.underflow !== 1'b1) begin
            errors++;
            $display("FAIL unf_priority: unf=%b expected 1", bus.underflow);
        end
        do_cycle(0, 0, '0, 1);
    endtask

    task automatic test_push_pop();
        do_cycle(1, 0, 12'h033, 0);
        do_cycle(1, 0, 12'h044, 0);
        do_cycle(1, 1, 12'h055, 0);
        checks++;
        if (bus.count !== 2 || bus.top_data !== 12'h055 || bus.underflow !== 1'b0) begin
            errors++;
            $display("FAIL pp_replace: count=%0d top=%h unf=%b expected 2 055 0",
                     bus.count, bus.top_data, bus.underflow);
        end
        do_cycle(0, 1, '0, 0);
        checks++;
        if (bus.top_data !== 12'h033) begin
            errors++;
            $display("FAIL pp_below: top=%h expected 033", bus.top_data);
        end
        do_cycle(0, 1, '0, 0);
        do_cycle(1, 1, 12'h066, 0);
        checks++;
        if (bus.count !== 1 || bus.top_data !== 12'h066 || bus.underflow !== 1'b1) begin
            errors++;
            $display("FAIL pp_empty: count=%0d top=%h unf=%b expected 1 066 1",
                     bus.count, bus.top_data, bus.underflow);
        end
        do_cycle(0, 1, '0, 1);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < DEPTH; i++) do_cycle(1, 0, WIDTH'(12'h100 + i), 0);
        do_cycle(1, 0, 12'h1FF, 0);
        for (int i = 0; i < DEPTH - 3; i++) do_cycle(0, 1, '0, 0);
        checks++;
        if (bus.count !== 3 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL arst_setup: count=%0d ovf=%b expected 3 1", bus.count, bus.overflow);
        end
        bus.push      = 1'b1;
        bus.push_data = 12'h0AA;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.count !== 0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
            bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.top_data !== '0) begin
            errors++;
            $display("FAIL arst_immediate: count=%0d empty=%b ovf=%b unf=%b top=%h expected 0 1 0 0 000",
                     bus.count, bus.empty, bus.overflow, bus.underflow, bus.top_data);
        end
        @(posedge clk);
        @(negedge clk);
        bus.push = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_cycle(1, 0, 12'h077, 0);
        checks++;
        if (bus.count !== 1 || bus.top_data !== 12'h077 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL arst_after: count=%0d top=%h ovf=%b expected 1 077 0",
                     bus.count, bus.top_data, bus.overflow);
        end
        do_cycle(0, 1, '0, 0);
    endtask

    task automatic test_random();
        int push_pct;
        int pop_pct;
        int bad;
        logic p, q, c;
        logic [WIDTH-1:0] d;
        bad = 0;
        push_pct = 50;
        pop_pct  = 50;
        for (int n = 0; n < 12000; n++) begin
            if (n % 250 == 0) begin
                push_pct = int'($urandom_range(10, 90));
                pop_pct  = int'($urandom_range(10, 90));
            end
            p = ($urandom_range(0, 99) < push_pct);
            q = ($urandom_range(0, 99) < pop_pct);
            c = ($urandom_range(0, 99) < 8);
            d = WIDTH'($urandom);
            bus.push = p; bus.pop = q; bus.push_data = d; bus.clr_err = c;
            #1;
            checks++;
            if (bus.top_data !== m_top()) begin
                errors++;
                bad++;
                if (bad < 10) $display("FAIL rand_pre_top: cycle %0d top=%h expected %h", n, bus.top_data, m_top());
            end
            do_cycle(p, q, d, c);
            checks++;
            if (bus.count !== m_count() || bus.top_data !== m_top() ||
                bus.empty !== (stk.size() == 0) || bus.full !== (stk.size() == DEPTH) ||
                bus.overflow !== m_ovf || bus.underflow !== m_unf || bus.count > CW'(DEPTH)) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_state: cycle %0d count=%0d/%0d top=%h/%h empty=%b full=%b ovf=%b/%b unf=%b/%b",
                             n, bus.count, m_count(), bus.top_data, m_top(), bus.empty, bus.full,
                             bus.overflow, m_ovf, bus.underflow, m_unf);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_push_pop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
